// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the acc_seq_ctrl sequencer and its datapath.
package acc_seq_pkg;

  localparam int W_DEF     = 4;
  localparam int CNT_W_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Command, operand-stream and result signals between the operand source and
// the accumulate sequencer.
interface acc_seq_ctrl_if #(
  parameter int W     = acc_seq_pkg::W_DEF,
  parameter int CNT_W = acc_seq_pkg::CNT_W_DEF
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [W-1:0]     in_data;
  logic             busy;
  logic             done;
  logic [W-1:0]     result;
  logic             ovf;

  modport master (
    output start, len, in_valid, in_op, in_data,
    input  in_ready, busy, done, result, ovf
  );

  modport slave (
    input  start, len, in_valid, in_op, in_data,
    output in_ready, busy, done, result, ovf
  );
endinterface

// File: rtl/acc.sv
// Combinational 4-bit add/subtract datapath: c=0 gives a+b, c=1 gives a-b,
// both wrapping modulo 16.
module acc (
  input  logic       c,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] saida
);
  assign saida = c ? (a - b) : (a + b);
endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencer around the acc datapath: takes a start+length command, folds each
// streamed operand into the running result and pulses done when finished.
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int           W     = W_DEF,
  parameter int           CNT_W = CNT_W_DEF,
  parameter logic [W-1:0] INIT  = '0
) (
  input  logic         clk,
  input  logic         reset,
  acc_seq_ctrl_if.slave bus
);

  state_e           state_q;
  logic [W-1:0]     result_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] rem_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic [W-1:0] saida;
  logic         accept;
  logic         last;
  logic         ovf_hit;

  acc u_acc (
    .c     (bus.in_op),
    .a     (result_q),
    .b     (bus.in_data),
    .saida (saida)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign last   = (count_q == rem_q - CNT_W'(1));

  // Unsigned carry shows up as a wrapped sum smaller than the old value;
  // a borrow happens whenever the subtrahend exceeds the old value.
  assign ovf_hit = ((bus.in_op == OP_ADD) && (saida < result_q)) ||
                   ((bus.in_op == OP_SUB) && (bus.in_data > result_q));

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      result_q   <= INIT;
      count_q    <= '0;
      rem_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            result_q <= INIT;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            rem_q    <= bus.len;
            if (bus.len != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            result_q <= saida;
            count_q  <= count_q + CNT_W'(1);
            if (ovf_hit) begin
              ovf_q <= 1'b1;
            end
            if (last) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Randomized and directed bench for acc_seq_ctrl against an arithmetic model
// of each command (wrapped sum/difference plus carry/borrow flag).
module tb_acc_seq_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  acc_seq_ctrl_if #(.W(4), .CNT_W(4)) bus ();

  acc_seq_ctrl #(.W(4), .CNT_W(4), .INIT(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Optional directed content; when a queue is empty the stimulus is random.
  int vq[$];
  int oq[$];
  int dq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one command of len_v operands; inputs change on negedge, outputs are
  // sampled on negedge before the new drive.
  task automatic run_cmd(input int len_v, input int gap_pct);
    int  exp_r;
    bit  exp_ovf;
    int  n_acc;
    int  cyc;
    int  v, op, d;
    exp_r   = 0;
    exp_ovf = 0;
    n_acc   = 0;
    cyc     = 0;
    @(negedge clk);
    check("idle_ready", bus.in_ready, 0);
    check("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.len   = 4'(len_v);
    @(negedge clk);
    bus.start = 1'b0;
    if (len_v != 0) begin
      check("run_busy", bus.busy, 1);
      check("run_ready", bus.in_ready, 1);
      while (n_acc < len_v && cyc < 300) begin
        v  = (vq.size() != 0) ? vq.pop_front() : int'($urandom_range(99) >= gap_pct);
        op = 0;
        d  = 0;
        if (v != 0) begin
          op = (oq.size() != 0) ? oq.pop_front() : int'($urandom_range(1));
          d  = (dq.size() != 0) ? dq.pop_front() : int'($urandom_range(15));
        end
        bus.in_valid = (v != 0);
        bus.in_op    = op[0];
        bus.in_data  = 4'(d);
        bus.start    = ($urandom_range(7) == 0);
        bus.len      = 4'($urandom_range(15));
        if (v != 0) begin
          if (op == 0) begin
            if (exp_r + d > 15) exp_ovf = 1;
            exp_r = (exp_r + d) % 16;
          end else begin
            if (d > exp_r) exp_ovf = 1;
            exp_r = (exp_r - d + 16) % 16;
          end
          n_acc++;
        end
        @(negedge clk);
        cyc++;
        check("run_result", bus.result, 32'(exp_r));
        if (n_acc < len_v) begin
          check("run_busy_hold", bus.busy, 1);
          check("run_no_done", bus.done, 0);
        end
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      if (cyc >= 300) check("accept_timeout", 0, 1);
    end
    check("done_pulse", bus.done, 1);
    check("done_busy", bus.busy, 0);
    check("done_ready", bus.in_ready, 0);
    check("done_result", bus.result, 32'(exp_r));
    check("done_ovf", bus.ovf, 32'(exp_ovf));
    // A start seen during DONE must be dropped.
    bus.start = 1'b1;
    bus.len   = 4'($urandom_range(1, 15));
    @(negedge clk);
    bus.start = 1'b0;
    check("done_once", bus.done, 0);
    check("post_ready", bus.in_ready, 0);
    check("post_busy", bus.busy, 0);
    check("hold_result", bus.result, 32'(exp_r));
    check("hold_ovf", bus.ovf, 32'(exp_ovf));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_op    = 1'b0;
    bus.in_data  = '0;
    reset        = 1'b1;
    #1;
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_result", bus.result, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Add chain 3+5+2, back to back.
    vq = '{1, 1, 1}; oq = '{0, 0, 0}; dq = '{3, 5, 2};
    run_cmd(3, 0);
    check("t1_result", bus.result, 4'b1010);
    check("t1_ovf", bus.ovf, 0);

    // Wrap with carry, then a fresh command clears ovf.
    vq = '{1, 1}; oq = '{0, 0}; dq = '{12, 7};
    run_cmd(2, 0);
    check("t2_result", bus.result, 4'b0011);
    check("t2_ovf", bus.ovf, 1);
    vq = '{1}; oq = '{0}; dq = '{1};
    run_cmd(1, 0);
    check("t2b_result", bus.result, 4'b0001);
    check("t2b_ovf", bus.ovf, 0);

    // Subtract with borrow.
    vq = '{1, 1}; oq = '{0, 1}; dq = '{2, 5};
    run_cmd(2, 0);
    check("t3_result", bus.result, 4'b1101);
    check("t3_ovf", bus.ovf, 1);

    // Gapped valid.
    vq = '{1, 0, 0, 1}; oq = '{0, 0}; dq = '{4, 6};
    run_cmd(2, 0);
    check("t4_result", bus.result, 4'd10);

    // Zero-length command.
    run_cmd(0, 0);
    check("t5_result", bus.result, 0);

    // Reset in the middle of a command.
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 4'd4;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = 1'b0;
    bus.in_data  = 4'd3;
    repeat (2) @(negedge clk);
    check("t6_partial", bus.result, 6);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    check("t6_rst_result", bus.result, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_ready", bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_done", bus.done, 0);
      check("t6_idle_busy", bus.busy, 0);
    end
    vq = '{1}; oq = '{1}; dq = '{1};
    run_cmd(1, 0);
    check("t6_new_result", bus.result, 4'd15);
    check("t6_new_ovf", bus.ovf, 1);

    // Random commands with random gaps and stray start pulses.
    for (int k = 0; k < 40; k++) begin
      int l;
      l = int'($urandom_range(15));
      if ($urandom_range(9) == 0) l = 0;
      run_cmd(l, int'($urandom_range(60)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
